// File: rtl/link_top.sv
// Linked-list manager: many singly-linked lists share one node RAM.
// Nodes come from a free stack of deleted nodes, then from a never-used bump pointer.

module link_ram #(
  parameter int ADDR_WIDTH = 16,
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WORD_WIDTH-1:0] wdata,
  output logic [WORD_WIDTH-1:0] rdata
);
  logic [WORD_WIDTH-1:0] memory [0:2**ADDR_WIDTH-1];

  // NOTE: the array has no reset; a reset loop over a RAM would turn it into flops.
  // NOTE: <= everywhere in clocked blocks, so rdata reads the pre-write word.
  always_ff @(posedge clk) begin
    if (we) memory[addr] <= wdata;
    rdata <= memory[addr];
  end
endmodule

module link_top #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int TABLE_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   order_valid,
  output logic                   order_busy,
  input  logic [1:0]             order_type,
  input  logic [TABLE_WIDTH-1:0] order_table,
  input  logic [ADDR_WIDTH-1:0]  order_node,
  input  logic [DATA_WIDTH-1:0]  order_data,
  output logic                   dout_valid,
  input  logic                   dout_busy,
  output logic [DATA_WIDTH-1:0]  dout_data
);
  localparam int WORD_WIDTH = ADDR_WIDTH + DATA_WIDTH;
  localparam int TABLES     = 2**TABLE_WIDTH;

  typedef enum logic [2:0] {IDLE, WALK, ALLOC, WRITE_NODE, LINK, UNLINK, FREE, OUTPUT} state_t;
  typedef enum logic [1:0] {OP_APPEND, OP_DELETE, OP_CHANGE, OP_READ} op_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

  state_t                 state;
  op_t                    op;
  logic [TABLE_WIDTH-1:0] tbl;
  data_t                  data_q, prev_data;
  addr_t                  heads [TABLES];
  addr_t                  lens  [TABLES];
  addr_t                  free_head, bump, cur, prev, hops, succ, new_node;
  logic                   phase;

  logic                  ram_we;
  addr_t                 ram_addr;
  logic [WORD_WIDTH-1:0] ram_wdata, ram_rdata;
  addr_t                 rd_next;
  data_t                 rd_data;

  assign {rd_next, rd_data} = ram_rdata;

  link_ram #(.ADDR_WIDTH(ADDR_WIDTH), .WORD_WIDTH(WORD_WIDTH)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  addr_t             cur_len, cur_head, app_pos;
  logic [ADDR_WIDTH:0] len_plus;
  logic              in_range, full;

  // APPEND position is clamped into [1, len+1]; the others need 1..len.
  always_comb begin
    cur_len  = lens[order_table];
    cur_head = heads[order_table];
    len_plus = {1'b0, cur_len} + (ADDR_WIDTH+1)'(1);
    in_range = (order_node != '0) && (order_node <= cur_len);
    full     = (free_head == '0) && (bump == '0);
    if (order_node == '0)                      app_pos = addr_t'(1);
    else if ({1'b0, order_node} > len_plus)    app_pos = len_plus[ADDR_WIDTH-1:0];
    else                                       app_pos = order_node;
  end

  // NOTE: every output of this block gets a default first, so no latches.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = cur;
    ram_wdata = {succ, data_q};
    case (state)
      ALLOC:      ram_addr = free_head;
      WRITE_NODE: begin
        ram_we   = 1'b1;
        ram_addr = (op == OP_CHANGE) ? cur : new_node;
      end
      LINK: begin
        ram_we    = (prev != '0);
        ram_addr  = prev;
        ram_wdata = {new_node, prev_data};
      end
      UNLINK: begin
        ram_we    = (prev != '0);
        ram_addr  = prev;
        ram_wdata = {succ, prev_data};
      end
      FREE: begin
        ram_we    = 1'b1;
        ram_wdata = {free_head, data_q};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op         <= OP_APPEND;
      tbl        <= '0;
      data_q     <= '0;
      prev_data  <= '0;
      free_head  <= '0;
      bump       <= addr_t'(1);
      cur        <= '0;
      prev       <= '0;
      hops       <= '0;
      succ       <= '0;
      new_node   <= '0;
      phase      <= 1'b0;
      order_busy <= 1'b0;
      dout_valid <= 1'b0;
      dout_data  <= '0;
      for (int i = 0; i < TABLES; i++) begin
        heads[i] <= '0;
        lens[i]  <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (order_valid && !order_busy) begin
            order_busy <= 1'b1;
            op         <= op_t'(order_type);
            tbl        <= order_table;
            data_q     <= order_data;
            cur        <= cur_head;
            prev       <= '0;
            phase      <= 1'b0;
            // Out-of-range and full orders stay in IDLE; busy clears next edge.
            case (op_t'(order_type))
              OP_APPEND: begin
                if (full) state <= IDLE;
                else if (app_pos == addr_t'(1)) begin
                  succ  <= cur_head;
                  state <= ALLOC;
                end else begin
                  hops  <= app_pos - addr_t'(2);
                  state <= WALK;
                end
              end
              OP_READ: begin
                if (in_range) begin
                  hops  <= order_node - addr_t'(1);
                  state <= WALK;
                end else begin
                  dout_data  <= '0;
                  dout_valid <= 1'b1;
                  state      <= OUTPUT;
                end
              end
              default: begin
                if (in_range) begin
                  hops  <= order_node - addr_t'(1);
                  state <= WALK;
                end
              end
            endcase
          end else begin
            order_busy <= 1'b0;
          end
        end
        // Each hop: one cycle to present cur, one to consume its word.
        WALK: begin
          phase <= ~phase;
          if (phase) begin
            if (hops != '0) begin
              prev      <= cur;
              prev_data <= rd_data;
              cur       <= rd_next;
              hops      <= hops - addr_t'(1);
            end else begin
              case (op)
                OP_APPEND: begin
                  prev      <= cur;
                  prev_data <= rd_data;
                  succ      <= rd_next;
                  state     <= ALLOC;
                end
                OP_DELETE: begin
                  succ  <= rd_next;
                  state <= UNLINK;
                end
                OP_CHANGE: begin
                  succ  <= rd_next;
                  state <= WRITE_NODE;
                end
                default: begin
                  dout_data  <= rd_data;
                  dout_valid <= 1'b1;
                  state      <= OUTPUT;
                end
              endcase
            end
          end
        end
        ALLOC: begin
          if (free_head == '0) begin
            new_node <= bump;
            bump     <= bump + addr_t'(1);
            state    <= WRITE_NODE;
          end else if (!phase) begin
            phase <= 1'b1;
          end else begin
            phase     <= 1'b0;
            new_node  <= free_head;
            free_head <= rd_next;
            state     <= WRITE_NODE;
          end
        end
        WRITE_NODE: begin
          if (op == OP_CHANGE) begin
            order_busy <= 1'b0;
            state      <= IDLE;
          end else begin
            state <= LINK;
          end
        end
        LINK: begin
          if (prev == '0) heads[tbl] <= new_node;
          lens[tbl]  <= lens[tbl] + addr_t'(1);
          order_busy <= 1'b0;
          state      <= IDLE;
        end
        UNLINK: begin
          if (prev == '0) heads[tbl] <= succ;
          state <= FREE;
        end
        FREE: begin
          free_head  <= cur;
          lens[tbl]  <= lens[tbl] - addr_t'(1);
          order_busy <= 1'b0;
          state      <= IDLE;
        end
        OUTPUT: begin
          if (!dout_busy) begin
            dout_valid <= 1'b0;
            order_busy <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_link_top.sv
// Self-checking bench for link_top: directed scenarios, then random orders
// against array-based list models.

module tb_link_top;
  localparam int MAXL = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        order_valid = 1'b0;
  logic        order_busy;
  logic [1:0]  order_type = 2'b00;
  logic [7:0]  order_table = '0;
  logic [15:0] order_node = '0;
  logic [15:0] order_data = '0;
  logic        dout_valid;
  logic        dout_busy = 1'b0;
  logic [15:0] dout_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] mdata [4][MAXL];
  int          mlen  [4];
  logic [7:0]  tmap  [4] = '{8'd0, 8'd1, 8'd3, 8'd255};

  link_top dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .order_valid (order_valid),
    .order_busy  (order_busy),
    .order_type  (order_type),
    .order_table (order_table),
    .order_node  (order_node),
    .order_data  (order_data),
    .dout_valid  (dout_valid),
    .dout_busy   (dout_busy),
    .dout_data   (dout_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int slot_of(input logic [7:0] t);
    for (int i = 0; i < 4; i++) if (tmap[i] == t) return i;
    return 0;
  endfunction

  function automatic int clamp_pos(input int s, input int p);
    if (p < 1) return 1;
    if (p > mlen[s] + 1) return mlen[s] + 1;
    return p;
  endfunction

  function automatic logic [15:0] model_get(input int s, input int p);
    if (p >= 1 && p <= mlen[s]) return mdata[s][p-1];
    return 16'd0;
  endfunction

  task automatic issue(input logic [1:0] ty, input logic [7:0] t, input logic [15:0] p, input logic [15:0] d);
    int n = 0;
    while (order_busy && n < 200) begin @(negedge clk); n++; end
    check("ready_before_order", order_busy, 1'b0);
    order_valid = 1'b1;
    order_type  = ty;
    order_table = t;
    order_node  = p;
    order_data  = d;
    @(negedge clk);
    order_valid = 1'b0;
    check("busy_after_accept", order_busy, 1'b1);
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (order_busy && n < bound) begin @(negedge clk); n++; end
    check("order_latency", order_busy, 1'b0);
  endtask

  task automatic do_append(input logic [7:0] t, input int p, input logic [15:0] d);
    int s = slot_of(t);
    int pp = clamp_pos(s, p);
    issue(2'b00, t, 16'(p), d);
    wait_done(2 * pp + 8);
    for (int i = mlen[s]; i >= pp; i--) mdata[s][i] = mdata[s][i-1];
    mdata[s][pp-1] = d;
    mlen[s]++;
  endtask

  task automatic do_delete(input logic [7:0] t, input int p);
    int s = slot_of(t);
    issue(2'b01, t, 16'(p), 16'd0);
    wait_done(2 * clamp_pos(s, p) + 8);
    if (p >= 1 && p <= mlen[s]) begin
      for (int i = p - 1; i < mlen[s] - 1; i++) mdata[s][i] = mdata[s][i+1];
      mlen[s]--;
    end
  endtask

  task automatic do_change(input logic [7:0] t, input int p, input logic [15:0] d);
    int s = slot_of(t);
    issue(2'b10, t, 16'(p), d);
    wait_done(2 * clamp_pos(s, p) + 8);
    if (p >= 1 && p <= mlen[s]) mdata[s][p-1] = d;
  endtask

  task automatic do_read(input logic [7:0] t, input int p, input logic [15:0] exp, input int stall);
    int n = 0;
    dout_busy = (stall > 0);
    issue(2'b11, t, 16'(p), 16'd0);
    while (!dout_valid && n < 2 * p + 20) begin @(negedge clk); n++; end
    check("read_valid", dout_valid, 1'b1);
    check("read_data", dout_data, exp);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_valid", dout_valid, 1'b1);
      check("stall_data", dout_data, exp);
      check("stall_busy", order_busy, 1'b1);
    end
    dout_busy = 1'b0;
    @(negedge clk);
    check("xfer_valid_drop", dout_valid, 1'b0);
    check("xfer_busy_drop", order_busy, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) mlen[i] = 0;
    repeat (3) @(negedge clk);
    check("reset_busy", order_busy, 1'b0);
    check("reset_valid", dout_valid, 1'b0);
    check("reset_data", dout_data, 16'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_append(8'd3, 1, 16'd111);
    do_append(8'd3, 2, 16'd112);
    do_append(8'd3, 3, 16'd113);
    do_read(8'd3, 1, 16'd111, 0);
    do_read(8'd3, 2, 16'd112, 0);
    do_read(8'd3, 3, 16'd113, 0);

    do_append(8'd1, 3, 16'd20);
    do_read(8'd1, 1, 16'd20, 0);
    do_read(8'd3, 3, 16'd113, 0);

    do_change(8'd3, 3, 16'd2);
    do_read(8'd3, 3, 16'd2, 0);
    do_read(8'd3, 2, 16'd112, 0);

    do_delete(8'd3, 2);
    do_read(8'd3, 2, 16'd2, 0);
    do_read(8'd3, 3, 16'd0, 0);
    do_append(8'd3, 1, 16'd7);
    check("freed_node_reused", 32'(dut.new_node), 32'd2);
    do_read(8'd3, 1, 16'd7, 0);
    do_read(8'd3, 2, 16'd111, 0);
    do_read(8'd3, 3, 16'd2, 10);

    // Boundary no-ops: position 0 and past the tail.
    do_delete(8'd3, 0);
    do_change(8'd3, 9, 16'd99);
    do_read(8'd3, 0, 16'd0, 0);
    do_read(8'd3, 3, 16'd2, 0);

    // Reset in the middle of a walk empties every list.
    issue(2'b11, 8'd3, 16'd3, 16'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midwalk_reset_busy", order_busy, 1'b0);
    check("midwalk_reset_valid", dout_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) mlen[i] = 0;
    @(negedge clk);
    do_read(8'd3, 1, 16'd0, 0);
    do_read(8'd1, 1, 16'd0, 0);

    for (int k = 0; k < 300; k++) begin
      int s = $urandom_range(0, 3);
      int p = $urandom_range(0, mlen[s] + 2);
      int ty = $urandom_range(0, 3);
      logic [15:0] d = 16'($urandom);
      if (mlen[s] >= 48 && ty == 0) ty = 1;
      case (ty)
        0: do_append(tmap[s], p, d);
        1: do_delete(tmap[s], p);
        2: do_change(tmap[s], p, d);
        default: do_read(tmap[s], p, model_get(s, p), $urandom_range(0, 3));
      endcase
    end
    for (int s = 0; s < 4; s++)
      for (int p = 1; p <= mlen[s] + 1; p++)
        do_read(tmap[s], p, model_get(s, p), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
